fpu_result_buffer: RTL and testbench
====================================

Name: fpu_result_buffer

Overview:
- Downstream stage of the combinational FP square-root unit. Captures its 64-bit result and four exception flags through a valid/ready handshake into a small FIFO.
- NaN-boxes single-precision results.
- On dequeue (commit), ORs each entry's flags into a sticky architectural exception-flag register (fflags).
- Decouples the combinational FPU datapath from the register-file writeback.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >=2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer holds a result this cycle.
- in_ready  output  1  buffer can accept an entry; registered-state derived, independent of out_ready.
- in_result  input  64  FP result; single precision in bits [31:0].
- in_is_double  input  1  1 = double, 0 = single.
- in_flag_invalid  input  1  NV from producer.
- in_flag_overflow  input  1  OF from producer.
- in_flag_underflow  input  1  UF from producer.
- in_flag_inexact  input  1  NX from producer.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head.
- out_result  output  64  head result, NaN-boxed.
- out_flags  output  4  head flags {NV,OF,UF,NX} (bit3..bit0).
- fflags  output  4  sticky accumulated flags, same bit order.
- fflags_clr  input  1  synchronous clear of fflags.
- count  output  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (async, rst_n=0):
  - Read pointer, write pointer, count and fflags go to 0.
  - out_valid=0, in_ready=1, out_result=0, out_flags=0.
  - Entry storage need not be reset.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH); out_valid = (count != 0).
- Push writes to the write pointer slot:
  - result = in_is_double ? in_result : {32'hFFFF_FFFF, in_result[31:0]}.
  - flags = {NV,OF,UF,NX}.
  - Write pointer increments mod DEPTH.
- Pop: read pointer increments mod DEPTH.
- out_result and out_flags come combinationally from the slot at the read pointer. When empty they are driven to 0.
- Latency: no bypass. An entry pushed in cycle N is first visible (out_valid=1) in cycle N+1.
- count: +1 on push only, -1 on pop only, unchanged on push&pop or on neither.
- Full (count==DEPTH):
  - in_ready=0, so in_valid is ignored and no write occurs.
  - A pop in the same cycle frees a slot; in_ready rises the next cycle.
- Empty (count==0): out_valid=0, so out_ready is ignored. A simultaneous push is legal.
- Pointers wrap from DEPTH-1 to 0 with no gap or duplication. Order is strict FIFO.
- fflags next value = (fflags_clr ? 4'b0 : fflags) | (pop ? out_flags : 4'b0).
  - When clear and pop coincide, the popped flags survive.
  - Flags are accumulated only on pop, never on push.
- Inputs are sampled only on push; the producer may change them freely otherwise.
- Reset mid-operation discards all entries and fflags immediately. out_valid falls asynchronously.

Optional Feature:
- Macro FPU_FLAG_IRQ_EN.
- Defined:
  - Adds input flag_irq_mask[3:0] and output flag_irq.
  - Adds an internal 4-bit register irq_pend, reset to 0.
  - Each cycle: irq_pend <= (fflags_clr ? 0 : irq_pend) | (pop ? out_flags & flag_irq_mask : 0).
  - flag_irq = |irq_pend, registered, asserted the cycle after the causing pop.
- Undefined: neither port nor irq_pend exists. All other behaviour is identical.

Test Plan:
- Double push, idle consumer: in_result=64'h4000_0000_0000_0000, in_is_double=1, flags 0.
  -> Next cycle out_valid=1, out_result=64'h4000_0000_0000_0000, out_flags=0, count=1.
- Single NaN-box: in_result=64'h1234_5678_3FB5_04F3, in_is_double=0, NX=1, then pop.
  -> out_result=64'hFFFF_FFFF_3FB5_04F3, out_flags=4'b0001; fflags=4'b0001 after pop.
- Fill and wrap with DEPTH=4, out_ready=0, push 5 values A..E.
  -> in_ready=0 after 4th push; E not stored; count=4.
  -> Then pop 1 and push E: pops return A,B,C,D,E in order.
- Simultaneous push+pop at count=2 -> count stays 2, order preserved.
- Sticky clear race: fflags=4'b1000, pop an entry with flags 4'b0100 while fflags_clr=1 -> fflags=4'b0100.
- Async reset with 3 entries queued: rst_n low mid-cycle.
  -> out_valid=0, count=0 and fflags=0 immediately, in_ready=1.
  -> With FPU_FLAG_IRQ_EN, mask=4'b1000 and an NV pop: flag_irq=1 the next cycle; it clears after fflags_clr.

Source files
------------

// File: rtl/fpu_result_buffer.sv
// rtl/fpu_result_buffer.sv - FIFO result buffer with NaN-boxing and sticky fflags for the FP sqrt unit
// Optional macro FPU_FLAG_IRQ_EN adds a masked flag interrupt (flag_irq_mask, flag_irq).
module fpu_result_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [63:0]                in_result,
  input  logic                       in_is_double,
  input  logic                       in_flag_invalid,
  input  logic                       in_flag_overflow,
  input  logic                       in_flag_underflow,
  input  logic                       in_flag_inexact,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [63:0]                out_result,
  output logic [3:0]                 out_flags,
  output logic [3:0]                 fflags,
  input  logic                       fflags_clr,
`ifdef FPU_FLAG_IRQ_EN
  input  logic [3:0]                 flag_irq_mask,
  output logic                       flag_irq,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    fflags_q, fflags_d;
  logic [63:0]   wr_result_d;
  logic [3:0]    wr_flags_d;
  logic          push, pop;

  logic [63:0]   mem_result_q [DEPTH];
  logic [3:0]    mem_flags_q  [DEPTH];

  assign in_ready   = (count_q != FULL);
  assign out_valid  = (count_q != '0);
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign out_result = out_valid ? mem_result_q[rd_ptr_q] : 64'h0;
  assign out_flags  = out_valid ? mem_flags_q[rd_ptr_q] : 4'h0;
  assign fflags     = fflags_q;
  assign count      = count_q;

  always_comb begin
    // Single-precision results are NaN-boxed into the upper word.
    wr_result_d = in_is_double ? in_result : {32'hFFFF_FFFF, in_result[31:0]};
    wr_flags_d  = {in_flag_invalid, in_flag_overflow, in_flag_underflow, in_flag_inexact};
    rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d     = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    fflags_d = (fflags_clr ? 4'h0 : fflags_q) | (pop ? out_flags : 4'h0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      fflags_q <= 4'h0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
    end
  end

  // Entry storage is left unreset; out_valid gates it from the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result_q[wr_ptr_q] <= wr_result_d;
      mem_flags_q[wr_ptr_q]  <= wr_flags_d;
    end
  end

`ifdef FPU_FLAG_IRQ_EN
  logic [3:0] irq_pend_q, irq_pend_d;

  always_comb begin
    irq_pend_d = (fflags_clr ? 4'h0 : irq_pend_q) | (pop ? (out_flags & flag_irq_mask) : 4'h0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_pend_q <= 4'h0;
    else        irq_pend_q <= irq_pend_d;
  end

  assign flag_irq = |irq_pend_q;
`endif

endmodule

// File: tb/tb_fpu_result_buffer.sv
// tb/tb_fpu_result_buffer.sv - scoreboard bench for fpu_result_buffer with a queue reference model
module tb_fpu_result_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_is_double;
  logic [63:0]   in_result, out_result;
  logic          nv, of, uf, nx;
  logic          out_valid, out_ready, fflags_clr;
  logic [3:0]    out_flags, fflags;
  logic [CW-1:0] count;
`ifdef FPU_FLAG_IRQ_EN
  logic [3:0]    flag_irq_mask;
  logic          flag_irq;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [63:0] res;
    logic [3:0]  flg;
  } ent_t;

  ent_t       sb[$];
  logic [3:0] m_ff;

  fpu_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_result         (in_result),
    .in_is_double      (in_is_double),
    .in_flag_invalid   (nv),
    .in_flag_overflow  (of),
    .in_flag_underflow (uf),
    .in_flag_inexact   (nx),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_result        (out_result),
    .out_flags         (out_flags),
    .fflags            (fflags),
    .fflags_clr        (fflags_clr),
`ifdef FPU_FLAG_IRQ_EN
    .flag_irq_mask     (flag_irq_mask),
    .flag_irq          (flag_irq),
`endif
    .count             (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of boxed entries plus the sticky flag word.
  logic       pop_m, push_m;
  logic [3:0] nff;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_ff = 4'h0;
    end else begin
      chk("count", 64'(count), 64'(sb.size()));
      chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(sb.size() != DEPTH));
      chk("fflags", 64'(fflags), 64'(m_ff));
      if (sb.size() != 0) begin
        chk("out_result", out_result, sb[0].res);
        chk("out_flags", 64'(out_flags), 64'(sb[0].flg));
      end else begin
        chk("out_result_empty", out_result, 64'h0);
        chk("out_flags_empty", 64'(out_flags), 64'h0);
      end
      pop_m  = (sb.size() != 0) && out_ready;
      push_m = (sb.size() != DEPTH) && in_valid;
      nff    = (fflags_clr ? 4'h0 : m_ff) | (pop_m ? sb[0].flg : 4'h0);
      if (pop_m) void'(sb.pop_front());
      if (push_m)
        sb.push_back({(in_is_double ? in_result : {32'hFFFF_FFFF, in_result[31:0]}),
                      {nv, of, uf, nx}});
      m_ff = nff;
    end
  end

  task automatic step(input logic v, input logic [63:0] r, input logic d,
                      input logic [3:0] f, input logic ordy, input logic clr);
    in_valid     = v;
    in_result    = r;
    in_is_double = d;
    {nv, of, uf, nx} = f;
    out_ready    = ordy;
    fflags_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_result = 64'h0; in_is_double = 1'b0;
    {nv, of, uf, nx} = 4'h0; out_ready = 1'b0; fflags_clr = 1'b0;
`ifdef FPU_FLAG_IRQ_EN
    flag_irq_mask = 4'b1000;
`endif
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_fflags", 64'(fflags), 64'h0);
    chk("rst_out_result", out_result, 64'h0);
    chk("rst_out_flags", 64'(out_flags), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Double push with idle consumer.
    step(1, 64'h4000_0000_0000_0000, 1, 4'h0, 0, 0);
    chk("dbl_out_valid", 64'(out_valid), 64'h1);
    chk("dbl_out_result", out_result, 64'h4000_0000_0000_0000);
    chk("dbl_count", 64'(count), 64'h1);
    step(0, 64'h0, 0, 4'h0, 1, 0);

    // Single precision NaN-box with NX, then pop.
    step(1, 64'h1234_5678_3FB5_04F3, 0, 4'b0001, 0, 0);
    chk("box_out_result", out_result, 64'hFFFF_FFFF_3FB5_04F3);
    chk("box_out_flags", 64'(out_flags), 64'h1);
    step(0, 64'h0, 0, 4'h0, 1, 0);
    chk("box_fflags", 64'(fflags), 64'h1);

    // Fill past DEPTH, then pop one and push E.
    for (int i = 0; i < 5; i++)
      step(1, {4'hA + 4'(i), 60'h0}, 1, 4'(i), 0, 0);
    chk("full_count", 64'(count), 64'(DEPTH));
    chk("full_in_ready", 64'(in_ready), 64'h0);
    step(0, 64'h0, 0, 4'h0, 1, 0);
    step(1, 64'hE000_0000_0000_0000, 1, 4'h4, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 64'h0, 0, 4'h0, 1, 0);

    // Simultaneous push and pop at count 2.
    step(1, 64'h1111, 1, 4'h2, 0, 0);
    step(1, 64'h2222, 1, 4'h0, 0, 0);
    step(1, 64'h3333, 1, 4'h8, 1, 0);
    chk("pp_count", 64'(count), 64'h2);
    for (int i = 0; i < 3; i++) step(0, 64'h0, 0, 4'h0, 1, 0);

    // Sticky clear racing a pop: popped flags survive.
    step(0, 64'h0, 0, 4'h0, 0, 1);
    step(1, 64'h5555, 1, 4'b1000, 0, 0);
    step(0, 64'h0, 0, 4'h0, 1, 0);
    chk("race_pre_fflags", 64'(fflags), 64'h8);
    step(1, 64'h6666, 1, 4'b0100, 0, 0);
    step(0, 64'h0, 0, 4'h0, 1, 1);
    chk("race_fflags", 64'(fflags), 64'h4);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    for (int i = 0; i < DEPTH + 2; i++) step(0, 64'h0, 0, 4'h0, 1, 0);

`ifdef FPU_FLAG_IRQ_EN
    step(0, 64'h0, 0, 4'h0, 0, 1);
    step(0, 64'h0, 0, 4'h0, 0, 0);
    chk("irq_idle", 64'(flag_irq), 64'h0);
    step(1, 64'h7777, 1, 4'b1000, 0, 0);
    chk("irq_no_push", 64'(flag_irq), 64'h0);
    step(0, 64'h0, 0, 4'h0, 1, 0);
    chk("irq_set", 64'(flag_irq), 64'h1);
    step(0, 64'h0, 0, 4'h0, 0, 1);
    chk("irq_clr", 64'(flag_irq), 64'h0);
`endif

    // Async reset with three entries queued and nonzero fflags.
    step(1, 64'h8888, 1, 4'hF, 0, 0);
    step(0, 64'h0, 0, 4'h0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 64'(i + 9), 1, 4'h3, 0, 0);
    in_valid = 1'b0;
    chk("pre_rst_count", 64'(count), 64'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'h0);
    chk("arst_count", 64'(count), 64'h0);
    chk("arst_fflags", 64'(fflags), 64'h0);
    chk("arst_in_ready", 64'(in_ready), 64'h1);
    chk("arst_out_result", out_result, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 64'h0, 0, 4'h0, 1, 0);
    step(0, 64'h0, 0, 4'h0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
